// File: rtl/swipt_pkg.sv
// Shared constants and helpers for the SWIPT link sequencer slice.
package swipt_pkg;

   localparam int unsigned STATE_W   = 3;
   localparam int unsigned FREQ_W    = 32;
   localparam int unsigned WRAP_W    = 16;
   localparam int unsigned BIT_IDX_W = 5;
   localparam int unsigned FRAME_BITS = 32;
   localparam int unsigned MIN_FREQ  = 64;

   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_RAMP   = 3'd1;
   localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
   localparam logic [STATE_W-1:0] ST_LOCKED = 3'd3;
   localparam logic [STATE_W-1:0] ST_DATA   = 3'd4;
   localparam logic [STATE_W-1:0] ST_FAULT  = 3'd5;

   // Carrier periods shorter than MIN_FREQ are not usable by the bridge.
   function automatic logic [FREQ_W-1:0] clamp_target(input logic [FREQ_W-1:0] f);
      return (f < FREQ_W'(MIN_FREQ)) ? FREQ_W'(MIN_FREQ) : f;
   endfunction

endpackage

// File: rtl/swipt_period_tick.sv
// Carrier period counter (0..period inclusive) with an N-wrap tick and a one-clock-early tick warning.
module swipt_period_tick
   import swipt_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_nrst,
   input  logic              run,
   input  logic [FREQ_W-1:0] period,
   input  logic [WRAP_W-1:0] n_wraps,
   output logic              tick_c,
   output logic              pre_tick_c
);

   logic [FREQ_W-1:0] cnt;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              wrap_c;
   logic              last_wrap_c;

   assign wrap_c      = run && (cnt == period);
   assign last_wrap_c = ((WRAP_W+1)'(wrap_cnt) + (WRAP_W+1)'(1)) >= (WRAP_W+1)'(n_wraps);
   assign tick_c      = wrap_c && last_wrap_c;
   assign pre_tick_c  = run && last_wrap_c &&
                        (((FREQ_W+1)'(cnt) + (FREQ_W+1)'(1)) == (FREQ_W+1)'(period));

   // Counters are held at zero while idle so every run starts on a fresh period.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cnt      <= '0;
         wrap_cnt <= '0;
      end else if (!run) begin
         cnt      <= '0;
         wrap_cnt <= '0;
      end else if (wrap_c) begin
         cnt      <= '0;
         wrap_cnt <= last_wrap_c ? '0 : wrap_cnt + WRAP_W'(1);
      end else begin
         cnt <= cnt + FREQ_W'(1);
      end
   end

endmodule

// File: rtl/swipt_link_sequencer.sv
// Session controller for the full-bridge PWM: soft-start ramp, settle/lock, and 32-bit frame scheduling.
module swipt_link_sequencer
   import swipt_pkg::*;
#(
   parameter int unsigned F_START     = 2000,
   parameter int unsigned F_STEP      = 8,
   parameter int unsigned STEP_CYCLES = 256,
   parameter int unsigned SETTLE_PER  = 64,
   parameter int unsigned BIT_PER     = 32
)(
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_fault,
   input  logic [FREQ_W-1:0]    i_target_freq,
   input  logic                 i_frame_valid,
   input  logic [FRAME_BITS-1:0] i_frame,
   output logic                 o_frame_ready,
   output logic                 o_enable,
   output logic                 o_lock,
   output logic                 o_data_mode,
   output logic [FREQ_W-1:0]    o_freq,
   output logic [FRAME_BITS-1:0] o_data_l,
   output logic [BIT_IDX_W-1:0] o_bit_idx,
   output logic                 o_frame_done,
   output logic                 o_fault
);

   localparam int unsigned STEP_W = $clog2(STEP_CYCLES) + 1;

   logic [STATE_W-1:0]    state_q, state_d;
   logic [FREQ_W-1:0]     tgt_q, tgt_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [FREQ_W-1:0]     freq_d;
   logic                  enable_d, lock_d, mode_d, ready_d, done_d, fault_d;
   logic [FRAME_BITS-1:0] data_d;
   logic [BIT_IDX_W-1:0]  idx_d;

   logic                  run_c, tick_c, pre_tick_c, accept_c, last_bit_c, to_idle_c;
   logic [WRAP_W-1:0]     n_wraps_c;
   logic [FREQ_W-1:0]     ramp_freq_c;

   assign run_c       = (state_q == ST_SETTLE) || (state_q == ST_DATA);
   assign n_wraps_c   = (state_q == ST_SETTLE) ? WRAP_W'(SETTLE_PER) : WRAP_W'(BIT_PER);
   assign accept_c    = i_frame_valid && o_frame_ready;
   assign last_bit_c  = (o_bit_idx == BIT_IDX_W'(FRAME_BITS - 1));
   // Saturating step toward the target; only consulted while o_freq > tgt_q.
   assign ramp_freq_c = ((o_freq - tgt_q) <= FREQ_W'(F_STEP)) ? tgt_q : (o_freq - FREQ_W'(F_STEP));

   swipt_period_tick u_tick (
      .i_clk      (i_clk),
      .i_nrst     (i_nrst),
      .run        (run_c),
      .period     (o_freq),
      .n_wraps    (n_wraps_c),
      .tick_c     (tick_c),
      .pre_tick_c (pre_tick_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      step_d    = '0;
      freq_d    = o_freq;
      enable_d  = o_enable;
      lock_d    = o_lock;
      mode_d    = o_data_mode;
      ready_d   = 1'b0;
      data_d    = o_data_l;
      idx_d     = o_bit_idx;
      done_d    = 1'b0;
      fault_d   = o_fault;
      to_idle_c = 1'b0;

      if (i_fault) begin
         state_d  = ST_FAULT;
         enable_d = 1'b0;
         lock_d   = 1'b0;
         mode_d   = 1'b0;
         data_d   = '0;
         idx_d    = '0;
         fault_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start && !i_stop) begin
                  state_d  = ST_RAMP;
                  tgt_d    = clamp_target(i_target_freq);
                  enable_d = 1'b1;
                  freq_d   = FREQ_W'(F_START);
               end
            end
            ST_RAMP: begin
               if (i_stop) begin
                  to_idle_c = 1'b1;
               end else if (o_freq <= tgt_q) begin
                  freq_d  = tgt_q;
                  state_d = ST_SETTLE;
               end else if (step_q == STEP_W'(STEP_CYCLES - 1)) begin
                  freq_d = ramp_freq_c;
                  if (ramp_freq_c == tgt_q) state_d = ST_SETTLE;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
            ST_SETTLE: begin
               if (i_stop) begin
                  to_idle_c = 1'b1;
               end else if (tick_c) begin
                  state_d = ST_LOCKED;
                  lock_d  = 1'b1;
                  ready_d = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (accept_c) begin
                  state_d = ST_DATA;
                  data_d  = i_frame;
                  idx_d   = '0;
                  mode_d  = 1'b1;
               end else if (i_stop) begin
                  to_idle_c = 1'b1;
               end else begin
                  ready_d = 1'b1;
               end
            end
            ST_DATA: begin
               if (tick_c && last_bit_c) begin
                  done_d = 1'b1;
                  if (accept_c) begin
                     data_d = i_frame;
                     idx_d  = '0;
                  end else if (i_stop) begin
                     to_idle_c = 1'b1;
                  end else begin
                     state_d = ST_LOCKED;
                     mode_d  = 1'b0;
                     ready_d = 1'b1;
                  end
               end else if (tick_c) begin
                  idx_d = o_bit_idx + BIT_IDX_W'(1);
               end else begin
                  // Ready opens only for the final clock of bit 31 so a queued frame follows gaplessly.
                  ready_d = pre_tick_c && last_bit_c && !i_stop;
               end
            end
            ST_FAULT: begin
               if (!i_start) begin
                  state_d = ST_IDLE;
                  fault_d = 1'b0;
                  freq_d  = FREQ_W'(F_START);
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (to_idle_c) begin
            state_d  = ST_IDLE;
            enable_d = 1'b0;
            lock_d   = 1'b0;
            mode_d   = 1'b0;
            data_d   = '0;
            idx_d    = '0;
            freq_d   = FREQ_W'(F_START);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q       <= ST_IDLE;
         tgt_q         <= '0;
         step_q        <= '0;
         o_freq        <= FREQ_W'(F_START);
         o_enable      <= 1'b0;
         o_lock        <= 1'b0;
         o_data_mode   <= 1'b0;
         o_frame_ready <= 1'b0;
         o_data_l      <= '0;
         o_bit_idx     <= '0;
         o_frame_done  <= 1'b0;
         o_fault       <= 1'b0;
      end else begin
         state_q       <= state_d;
         tgt_q         <= tgt_d;
         step_q        <= step_d;
         o_freq        <= freq_d;
         o_enable      <= enable_d;
         o_lock        <= lock_d;
         o_data_mode   <= mode_d;
         o_frame_ready <= ready_d;
         o_data_l      <= data_d;
         o_bit_idx     <= idx_d;
         o_frame_done  <= done_d;
         o_fault       <= fault_d;
      end
   end

endmodule

// File: tb/tb_swipt_link_sequencer.sv
// Directed self-checking bench for swipt_link_sequencer with a frame scoreboard.
module tb_swipt_link_sequencer;

   localparam int BIT_CLKS   = 202;
   localparam int FRAME_CLKS = 32 * BIT_CLKS;

   logic        clk, nrst, start, stop, fault, valid;
   logic [31:0] target, frame;
   logic        ready, enable, lock, data_mode, frame_done, fault_o;
   logic [31:0] freq, data_l;
   logic [4:0]  bit_idx;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   swipt_link_sequencer #(
      .F_START(200), .F_STEP(10), .STEP_CYCLES(4), .SETTLE_PER(2), .BIT_PER(2)
   ) dut (
      .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_stop(stop), .i_fault(fault),
      .i_target_freq(target), .i_frame_valid(valid), .i_frame(frame),
      .o_frame_ready(ready), .o_enable(enable), .o_lock(lock), .o_data_mode(data_mode),
      .o_freq(freq), .o_data_l(data_l), .o_bit_idx(bit_idx), .o_frame_done(frame_done),
      .o_fault(fault_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [31:0] d);
      chk("ready_locked", 32'(ready), 32'd1);
      valid = 1'b1;
      frame = d;
      exp_q.push_back(d);
      tick();
      valid = 1'b0;
      chk("ready_drop", 32'(ready), 32'd0);
   endtask

   // Runs one frame from its first DATA clock through the frame_done clock.
   task automatic run_frame(input bit stop_mid, input bit nxt, input logic [31:0] nxt_data);
      int          dones;
      logic [31:0] e;
      chk("sb_depth", 32'(exp_q.size()), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("data_l", data_l, e);
      chk("bit_idx_first", 32'(bit_idx), 32'd0);
      chk("data_mode_on", 32'(data_mode), 32'd1);
      chk("ready_in_frame", 32'(ready), 32'd0);
      dones = 0;
      for (int c = 1; c < FRAME_CLKS; c++) begin
         tick();
         if (frame_done) dones++;
         if (stop_mid && c == BIT_CLKS * 10) stop = 1'b1;
         if ((c % BIT_CLKS) == 0 || (c % BIT_CLKS) == BIT_CLKS - 1)
            chk("bit_idx", 32'(bit_idx), 32'(c / BIT_CLKS));
         if (c == FRAME_CLKS - 2) chk("ready_early", 32'(ready), 32'd0);
      end
      chk("no_early_done", 32'(dones), 32'd0);
      chk("ready_last_clk", 32'(ready), stop_mid ? 32'd0 : 32'd1);
      if (nxt) begin
         valid = 1'b1;
         frame = nxt_data;
         exp_q.push_back(nxt_data);
      end
      tick();
      valid = 1'b0;
      chk("frame_done", 32'(frame_done), 32'd1);
   endtask

   task automatic bring_up(input logic [31:0] tgt, input logic [31:0] exp_tgt);
      logic [31:0] min_f;
      bit          locked;
      target = tgt;
      start  = 1'b1;
      tick();
      chk("ramp_enable", 32'(enable), 32'd1);
      chk("ramp_first_freq", freq, 32'd200);
      start  = 1'b0;
      min_f  = freq;
      locked = 1'b0;
      for (int k = 0; k < 3000 && !locked; k++) begin
         tick();
         if (freq < min_f) min_f = freq;
         locked = lock;
      end
      chk("lock_timeout", 32'(locked), 32'd1);
      chk("final_freq", freq, exp_tgt);
      chk("min_freq", min_f, exp_tgt);
   endtask

   task automatic stop_locked();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_enable", 32'(enable), 32'd0);
      chk("stop_lock", 32'(lock), 32'd0);
      chk("stop_ready", 32'(ready), 32'd0);
      chk("stop_freq", freq, 32'd200);
   endtask

   initial begin
      int   dones;
      bit   locked;
      logic [31:0] e;
      clk = 0; nrst = 0; start = 0; stop = 0; fault = 0; valid = 0;
      target = 32'd0; frame = 32'd0;
      repeat (3) tick();

      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_lock", 32'(lock), 32'd0);
      chk("rst_mode", 32'(data_mode), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_freq", freq, 32'd200);
      chk("rst_data_l", data_l, 32'd0);
      chk("rst_bit_idx", 32'(bit_idx), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);
      nrst = 1'b1;
      tick();

      // Soft-start ramp 200 -> 100 in steps of 10 every 4 clocks, then 202 clocks of settle.
      target = 32'd100;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk("ramp_enable", 32'(enable), 32'd1);
      chk("ramp_freq_0", freq, 32'd200);
      for (int k = 1; k <= 40; k++) begin
         tick();
         chk("ramp_freq", freq, 32'(200 - 10 * (k / 4)));
      end
      for (int j = 1; j <= 201; j++) tick();
      chk("settle_no_lock", 32'(lock), 32'd0);
      chk("settle_freq", freq, 32'd100);
      tick();
      chk("lock_on", 32'(lock), 32'd1);

      accept(32'hA5A5_0F0F);
      run_frame(1'b0, 1'b0, 32'd0);
      chk("back_locked_mode", 32'(data_mode), 32'd0);
      chk("back_locked_ready", 32'(ready), 32'd1);
      chk("back_locked_lock", 32'(lock), 32'd1);

      accept(32'h1122_3344);
      run_frame(1'b0, 1'b1, 32'h5566_7788);
      run_frame(1'b0, 1'b0, 32'd0);
      chk("b2b_end_mode", 32'(data_mode), 32'd0);

      accept(32'hDEAD_BEEF);
      run_frame(1'b1, 1'b0, 32'd0);
      stop = 1'b0;
      chk("midstop_enable", 32'(enable), 32'd0);
      chk("midstop_mode", 32'(data_mode), 32'd0);
      chk("midstop_freq", freq, 32'd200);

      // Stop during ramp, then start+stop together.
      target = 32'd100;
      start  = 1'b1;
      tick();
      chk("ramp2_enable", 32'(enable), 32'd1);
      stop = 1'b1;
      tick();
      chk("ramp_stop_enable", 32'(enable), 32'd0);
      tick();
      chk("start_stop_idle", 32'(enable), 32'd0);
      start = 1'b0;
      stop  = 1'b0;
      tick();

      // Fault during bit 5.
      bring_up(32'd100, 32'd100);
      tick();
      accept(32'hF00D_CAFE);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("fault_frame_data", data_l, e);
      for (int c = 1; c <= BIT_CLKS * 5 + 10; c++) tick();
      chk("fault_pre_idx", 32'(bit_idx), 32'd5);
      fault = 1'b1;
      start = 1'b1;
      tick();
      chk("fault_enable", 32'(enable), 32'd0);
      chk("fault_lock", 32'(lock), 32'd0);
      chk("fault_mode", 32'(data_mode), 32'd0);
      chk("fault_ready", 32'(ready), 32'd0);
      chk("fault_flag", 32'(fault_o), 32'd1);
      dones = 0;
      for (int c = 0; c < FRAME_CLKS; c++) begin
         tick();
         if (frame_done) dones++;
      end
      chk("fault_no_done", 32'(dones), 32'd0);
      fault = 1'b0;
      repeat (3) tick();
      chk("fault_hold_start", 32'(fault_o), 32'd1);
      start = 1'b0;
      tick();
      chk("fault_clear", 32'(fault_o), 32'd0);
      chk("fault_exit_freq", freq, 32'd200);
      chk("fault_exit_enable", 32'(enable), 32'd0);

      // Target below the minimum is clamped to 64.
      bring_up(32'd20, 32'd64);
      stop_locked();

      // Target above the start period jumps straight to it.
      target = 32'd300;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk("hi_ramp_freq", freq, 32'd200);
      tick();
      chk("hi_settle_freq", freq, 32'd300);
      locked = 1'b0;
      for (int k = 0; k < 1000 && !locked; k++) begin
         tick();
         locked = lock;
      end
      chk("hi_lock", 32'(locked), 32'd1);
      chk("hi_lock_freq", freq, 32'd300);
      stop_locked();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
